// File: rtl/piso_fifo_spi.sv
// Streams the frequency indices of one FFT frame's spectral maxima to an MCU:
// a PISO unloads the peaks into a FIFO, and a mode-0 SPI master drains it as 16-bit frames.
module piso_fifo_spi #(
  parameter int unsigned DSIZE     = 9,
  parameter int unsigned ASIZE     = 13,
  parameter int unsigned NUM_PEAKS = 16,
  parameter int unsigned HALF_DIV  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_PEAKS*25-1:0] data_in,
  output logic                    piso_active,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs,
  output logic                    data_ready
);

  localparam int unsigned Depth  = 2 ** ASIZE;
  localparam int unsigned IdxW   = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam int unsigned FrameW = 16;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned DivW   = $clog2(2 * HALF_DIV);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  // ---------------------------------------------------------------------------
  // PISO: only the frequency field of each entry is kept
  // ---------------------------------------------------------------------------
  logic [DSIZE-1:0] peak_q [NUM_PEAKS];
  logic             piso_busy_q;
  logic [IdxW-1:0]  piso_idx_q;
  logic [DSIZE-1:0] piso_word_q;
  logic             piso_active_q;
  logic             unused_data;

  assign unused_data = ^data_in;

  always_ff @(posedge clk) begin
    if (load && !piso_busy_q) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        peak_q[i] <= data_in[25*i+16 +: DSIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      piso_busy_q   <= 1'b0;
      piso_idx_q    <= '0;
      piso_word_q   <= '0;
      piso_active_q <= 1'b0;
    end else begin
      piso_active_q <= piso_busy_q;
      if (piso_busy_q) begin
        piso_word_q <= peak_q[piso_idx_q];
        piso_idx_q  <= piso_idx_q + 1'b1;
        if (piso_idx_q == IdxW'(NUM_PEAKS - 1)) begin
          piso_busy_q <= 1'b0;
        end
      end else if (load) begin
        piso_busy_q <= 1'b1;
        piso_idx_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DSIZE-1:0] mem [Depth];
  logic [ASIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [ASIZE:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic [DSIZE-1:0] rd_data_q;
  logic             wr_en, rd_en;

  assign wr_en = piso_active_q && !full_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= piso_word_q;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Flags are registered from the next occupancy so a write can never overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (ASIZE + 1)'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // SPI master, mode 0, MSB first
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [FrameW-1:0] sr_q, sr_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              dr_q, dr_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dr_d    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      StIdle: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        if (!empty_q) begin
          rd_en   = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        sr_d    = {{(FrameW - DSIZE){1'b0}}, rd_data_q};
        mosi_d  = sr_d[FrameW-1];
        cs_d    = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == DivW'(HALF_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitW'(FrameW - 1)) begin
              cs_d    = 1'b1;
              dr_d    = 1'b1;
              mosi_d  = 1'b0;
              state_d = StGap;
            end else begin
              // Next bit is presented on the falling edge; the slave samples on the rise.
              sr_d   = {sr_q[FrameW-2:0], 1'b0};
              mosi_d = sr_q[FrameW-2];
              bit_d  = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_q == DivW'(2 * HALF_DIV - 1)) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      dr_q    <= dr_d;
    end
  end

  assign piso_active = piso_active_q;
  assign fifo_full   = full_q;
  assign fifo_empty  = empty_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs          = cs_q;
  assign data_ready  = dr_q;

endmodule

// File: tb/tb_piso_fifo_spi.sv
// Bench for piso_fifo_spi: a queue-based reference of accepted bursts is checked against
// frames decoded from the SPI pins; a small-FIFO instance covers overflow dropping.
module tb_piso_fifo_spi;

  localparam int unsigned HALF_DIV = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         load = 1'b0, load2 = 1'b0;
  logic [399:0] data_in = '0, data2 = '0;
  logic piso_active, fifo_full, fifo_empty, sclk, mosi, cs, data_ready;
  logic piso_active2, fifo_full2, fifo_empty2, sclk2, mosi2, cs2, data_ready2;

  piso_fifo_spi #(.DSIZE(9), .ASIZE(13), .NUM_PEAKS(16), .HALF_DIV(HALF_DIV)) u_dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .piso_active(piso_active), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .sclk(sclk), .mosi(mosi), .cs(cs), .data_ready(data_ready)
  );

  piso_fifo_spi #(.DSIZE(9), .ASIZE(2), .NUM_PEAKS(16), .HALF_DIV(HALF_DIV)) u_dut_small (
    .clk(clk), .reset(reset), .load(load2), .data_in(data2),
    .piso_active(piso_active2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
    .sclk(sclk2), .mosi(mosi2), .cs(cs2), .data_ready(data_ready2)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: words owed by the SPI link, in order.
  logic [8:0] exp_q[$];
  int         tick = 0;
  int         next_free = 0;
  logic [8:0] fr [16];

  task automatic cyc();
    @(negedge clk);
    tick++;
  endtask

  // A load is honoured only when no burst occupies the 16 following edges.
  task automatic arm_load();
    logic [399:0] d;
    for (int i = 0; i < 16; i++) d[25*i +: 25] = {fr[i], 16'($urandom)};
    data_in = d;
    load    = 1'b1;
    if (tick >= next_free) begin
      for (int i = 0; i < 16; i++) exp_q.push_back(fr[i]);
      next_free = tick + 17;
    end
  endtask

  task automatic drive_load();
    arm_load();
    cyc();
    load    = 1'b0;
    data_in = {13{$urandom}};
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (exp_q.size() == 0 && cs === 1'b1 && fifo_empty === 1'b1) break;
    end
    check("drain_words_left", exp_q.size(), 0);
    repeat (20) cyc();
  endtask

  // Main-link monitor, sampled on the falling clock edge.
  logic       rst_seen = 1'b1;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, frame_end;
  logic [15:0] sh = '0;
  int nrise = 0, mcyc = 0, fall_cyc = 0, last_rise = 0;
  int frames = 0, dr_cnt = 0, act_cnt = 0;

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    mcyc++;
    if (piso_active === 1'b1) act_cnt++;
    if (data_ready === 1'b1) dr_cnt++;
    if (rst_seen) begin
      in_frame = 1'b0;
      nrise    = 0;
    end else begin
      if (prev_cs && !cs) begin
        in_frame = 1'b1;
        nrise    = 0;
        sh       = '0;
        fall_cyc = mcyc;
      end
      if (!prev_sclk && sclk) begin
        check("cs_low_at_rise", cs, 1'b0);
        sh = {sh[14:0], mosi};
        nrise++;
        if (nrise == 1) check("first_rise_delay", mcyc - fall_cyc, HALF_DIV);
        else            check("sclk_period", mcyc - last_rise, 2 * HALF_DIV);
        last_rise = mcyc;
      end
      frame_end = !prev_cs && cs && in_frame;
      check("data_ready_timing", data_ready, frame_end);
      if (frame_end) begin
        in_frame = 1'b0;
        frames++;
        check("rises_per_frame", nrise, 16);
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("frame_word", sh, {7'b0, exp_q.pop_front()});
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  // Small-FIFO monitor: just collects frames.
  logic        p2_cs = 1'b1, p2_sclk = 1'b0, full2_seen = 1'b0;
  logic [15:0] sh2 = '0;
  logic [15:0] rx2[$];

  always @(negedge clk) begin
    if (fifo_full2 === 1'b1) full2_seen = 1'b1;
    if (!p2_sclk && sclk2) sh2 = {sh2[14:0], mosi2};
    if (!p2_cs && cs2) rx2.push_back(sh2);
    p2_cs   = cs2;
    p2_sclk = sclk2;
  end

  typedef struct {
    logic       rst;
    logic       ld;
    logic [6:0] exp;  // {piso_active, fifo_full, fifo_empty, sclk, mosi, cs, data_ready}
  } vec_t;

  vec_t vt[7];

  initial begin
    int         bad;
    int         a0, f0, d0;
    logic [8:0] kept[5];

    vt[0] = '{1'b1, 1'b0, 7'b0010010};
    vt[1] = '{1'b0, 1'b1, 7'b0010010};  // load edge
    vt[2] = '{1'b0, 1'b0, 7'b1010010};  // first word emitted
    vt[3] = '{1'b0, 1'b0, 7'b1000010};  // first word written
    vt[4] = '{1'b0, 1'b0, 7'b1000010};  // popped
    vt[5] = '{1'b0, 1'b0, 7'b1000000};  // frame opens
    vt[6] = '{1'b0, 1'b0, 7'b1000000};

    // Reset held 20 cycles
    reset = 1'b1;
    bad   = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sclk !== 1'b0 || cs !== 1'b1) bad++;
    end
    check("reset_idle_pins", bad, 0);
    check("reset_outputs", {piso_active, fifo_full, fifo_empty, sclk, mosi, cs, data_ready},
          7'b0010010);
    check("reset_outputs_small", {piso_active2, fifo_full2, fifo_empty2, sclk2, mosi2, cs2,
          data_ready2}, 7'b0010010);

    // Burst of freq 1..16, cycle-exact opening via the vector table
    for (int i = 0; i < 16; i++) fr[i] = 9'(i + 1);
    a0 = act_cnt; f0 = frames; d0 = dr_cnt;
    for (int v = 0; v < 7; v++) begin
      reset = vt[v].rst;
      if (vt[v].rst) begin
        exp_q.delete();
        next_free = tick + 1;
      end
      if (vt[v].ld) arm_load();
      cyc();
      load = 1'b0;
      check($sformatf("table_vec%0d", v),
            {piso_active, fifo_full, fifo_empty, sclk, mosi, cs, data_ready}, vt[v].exp);
    end
    data_in = {13{$urandom}};
    wait_drain(6000);
    check("burst_active_cycles", act_cnt - a0, 16);
    check("burst_frames", frames - f0, 16);
    check("burst_data_ready", dr_cnt - d0, 16);

    // First word 0x1A5 exercises a mixed bit pattern
    fr[0] = 9'h1A5;
    for (int i = 1; i < 16; i++) fr[i] = 9'($urandom);
    drive_load();
    wait_drain(6000);

    // Small FIFO: two back-to-back bursts overflow it
    for (int i = 0; i < 16; i++) fr[i] = 9'($urandom);
    for (int i = 0; i < 5; i++) kept[i] = fr[i];
    for (int i = 0; i < 16; i++) data2[25*i +: 25] = {fr[i], 16'($urandom)};
    load2 = 1'b1;
    cyc();
    load2 = 1'b0;
    repeat (16) cyc();
    for (int i = 0; i < 16; i++) data2[25*i +: 25] = {9'($urandom), 16'($urandom)};
    load2 = 1'b1;
    cyc();
    load2 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (rx2.size() >= 5) break;
    end
    repeat (400) cyc();
    check("small_full_seen", full2_seen, 1'b1);
    // Depth 4 plus the one word popped before the FIFO filled
    check("small_frames", rx2.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx2.size()) check($sformatf("small_word%0d", i), rx2[i], {7'b0, kept[i]});
    end
    check("small_empty_after", fifo_empty2, 1'b1);

    // Load pulsed again during a burst is ignored
    for (int i = 0; i < 16; i++) fr[i] = 9'($urandom);
    a0 = act_cnt; f0 = frames;
    drive_load();
    repeat (5) cyc();
    for (int i = 0; i < 16; i++) fr[i] = 9'($urandom);
    drive_load();
    wait_drain(6000);
    check("reload_active_cycles", act_cnt - a0, 16);
    check("reload_frames", frames - f0, 16);

    // Randomised load pulses, some landing inside a burst
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 24)) cyc();
      for (int i = 0; i < 16; i++) fr[i] = 9'($urandom);
      drive_load();
    end
    wait_drain(20000);

    // Reset mid-frame, then a clean burst
    for (int i = 0; i < 16; i++) fr[i] = 9'(i + 1);
    drive_load();
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (nrise >= 5 && in_frame) break;
    end
    check("mid_frame_reached", nrise >= 5, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    next_free = tick + 1;
    cyc();
    check("abort_pins", {cs, sclk, fifo_empty, piso_active}, 4'b1010);
    reset = 1'b0;
    cyc();
    a0 = act_cnt; f0 = frames;
    drive_load();
    wait_drain(6000);
    check("after_abort_active", act_cnt - a0, 16);
    check("after_abort_frames", frames - f0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
